mor1kx_trace_packetizer: RTL and testbench

Consumes the per-instruction execution trace port of the mor1kx core wrapper (`mor1kx_trace_exec` struct) and filters it into typed trace records. Records are buffered in a small synchronous FIFO and delivered over a valid/ready stream to the debug trace sink. On FIFO overflow, dropped events are counted and reported in-band as an OVERFLOW record, so software can detect gaps. The block sits directly downstream of the core wrapper, in the same clock domain as the core.

---
 rtl/mor1kx_trace_packetizer_pkg.sv | 35 +++
 rtl/mor1kx_trace_packetizer_if.sv | 11 +
 rtl/trace_sync_fifo.sv | 50 +++++
 rtl/mor1kx_trace_packetizer.sv | 96 +++++++++
 tb/tb_mor1kx_trace_packetizer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mor1kx_trace_packetizer_pkg.sv
// Shared types for the mor1kx execution-trace packetizer: the core trace port
// struct, trace record layout and record type codes.
package mor1kx_trace_packetizer_pkg;

  localparam int unsigned TRACE_RECORD_W = 72;

  typedef enum logic [2:0] {
    TraceExec     = 3'd1,
    TraceBranch   = 3'd2,
    TraceRegwb    = 3'd3,
    TraceOverflow = 3'd4
  } trace_type_e;

  // Field order matches the serialised record {type, tag, a, b}.
  typedef struct packed {
    logic [2:0]  rtype;
    logic [4:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
  } trace_record_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        jb;
    logic        jal;
    logic        jr;
    logic [31:0] jbtarget;
    logic [31:0] insn;
    logic [31:0] wbdata;
    logic [4:0]  wbreg;
    logic        wben;
  } mor1kx_trace_exec;

endpackage

// File: rtl/mor1kx_trace_packetizer_if.sv
// Valid/ready record stream from the packetizer to the debug trace sink.
interface mor1kx_trace_packetizer_if;
  import mor1kx_trace_packetizer_pkg::*;

  logic                      valid;
  logic                      ready;
  logic [TRACE_RECORD_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/trace_sync_fifo.sv
// Synchronous first-word fall-through FIFO with extra-MSB pointers and an
// occupancy output; read data is zero while empty.
module trace_sync_fifo #(
  parameter int unsigned WIDTH = 72,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty;
    valid_o = ~empty;
    rdata_o = empty ? '0 : mem_q[rd_q[AW-1:0]];
    level_o = wr_q - rd_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrOne;
      if (do_pop)  rd_q <= rd_q + PtrOne;
    end
  end

  // Storage needs no reset: it is only observable through a non-empty pointer pair.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mor1kx_trace_packetizer.sv
// Classifies mor1kx execution trace events into typed records, buffers them and
// reports FIFO overflow in-band with a saturating drop count.
module mor1kx_trace_packetizer
  import mor1kx_trace_packetizer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  mor1kx_trace_exec            trace_exec,
  input  logic                        trace_en_i,
  input  logic [2:0]                  filter_i,
  mor1kx_trace_packetizer_if.master   out,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic                        drop_pending_o
);

  localparam logic [CNT_W-1:0] CntOne = 1;

  logic [CNT_W-1:0] drop_q, drop_d;
  logic             branch_m, regwb_m, exec_m, event_hit;
  logic             fifo_full, push;
  trace_record_t    ev_rec, ov_rec, wr_rec;

  always_comb begin
    branch_m  = filter_i[1] & trace_exec.jb;
    regwb_m   = filter_i[2] & trace_exec.wben;
    exec_m    = filter_i[0];
    event_hit = trace_exec.valid & trace_en_i & (branch_m | regwb_m | exec_m);

    ev_rec   = '0;
    ev_rec.a = trace_exec.pc;
    if (branch_m) begin
      ev_rec.rtype = TraceBranch;
      ev_rec.tag   = {trace_exec.jal, trace_exec.jr, 3'b000};
      ev_rec.b     = trace_exec.jbtarget;
    end else if (regwb_m) begin
      ev_rec.rtype = TraceRegwb;
      ev_rec.tag   = trace_exec.wbreg;
      ev_rec.b     = trace_exec.wbdata;
    end else begin
      ev_rec.rtype = TraceExec;
      ev_rec.b     = trace_exec.insn;
    end

    ov_rec       = '0;
    ov_rec.rtype = TraceOverflow;
    ov_rec.a     = 32'(drop_q);
  end

  // Full is judged on registered state, so a same-cycle pop never frees a slot.
  always_comb begin
    push   = 1'b0;
    wr_rec = ev_rec;
    drop_d = drop_q;
    if (!fifo_full) begin
      if (drop_q != '0) begin
        // Pending count is flushed first; a coincident event becomes the new drop.
        push   = 1'b1;
        wr_rec = ov_rec;
        drop_d = event_hit ? CntOne : '0;
      end else begin
        push = event_hit;
      end
    end else if (event_hit) begin
      drop_d = (drop_q == '1) ? drop_q : drop_q + CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_pending_o = (drop_q != '0);

  trace_sync_fifo #(
    .WIDTH (TRACE_RECORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (wr_rec),
    .pop_i   (out.ready),
    .rdata_o (out.data),
    .valid_o (out.valid),
    .full_o  (fifo_full),
    .level_o (level_o)
  );

endmodule

// File: tb/tb_mor1kx_trace_packetizer.sv
// Directed bench for the trace packetizer; a second instance with a 4-bit drop
// counter shares all stimulus to exercise counter saturation.
module tb_mor1kx_trace_packetizer;
  import mor1kx_trace_packetizer_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  mor1kx_trace_exec te;
  logic             en;
  logic [2:0]       filter;
  logic             ready;
  logic [4:0]       lvl1, lvl2;
  logic             dp1, dp2;
  int               checks = 0;
  int               failures = 0;

  always #5 clk = ~clk;

  mor1kx_trace_packetizer_if o1 ();
  mor1kx_trace_packetizer_if o2 ();
  assign o1.ready = ready;
  assign o2.ready = ready;

  mor1kx_trace_packetizer #(.DEPTH(16), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .trace_exec(te), .trace_en_i(en), .filter_i(filter),
    .out(o1), .level_o(lvl1), .drop_pending_o(dp1)
  );

  mor1kx_trace_packetizer #(.DEPTH(16), .CNT_W(4)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .trace_exec(te), .trace_en_i(en), .filter_i(filter),
    .out(o2), .level_o(lvl2), .drop_pending_o(dp2)
  );

  function automatic logic [71:0] rec(input logic [2:0] t, input logic [4:0] g,
                                      input logic [31:0] a, input logic [31:0] b);
    return {t, g, a, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    te = '0;
  endtask

  task automatic drive_ev(input logic jb, input logic jal, input logic jr, input logic wben,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [31:0] insn, input logic [31:0] wbd,
                          input logic [4:0] wreg);
    te.valid = 1'b1;  te.pc = pc;     te.jb = jb;     te.jal = jal;   te.jr = jr;
    te.jbtarget = tgt; te.insn = insn; te.wbdata = wbd; te.wbreg = wreg; te.wben = wben;
  endtask

  task automatic test_reset();
    checks++; if (o1.valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid got=%b exp=0", o1.valid); end
    checks++; if (o1.data !== 72'h0) begin failures++;
      $display("FAIL reset_data got=%h exp=0", o1.data); end
    checks++; if (lvl1 !== 5'd0) begin failures++;
      $display("FAIL reset_level got=%0d exp=0", lvl1); end
    checks++; if (dp1 !== 1'b0) begin failures++;
      $display("FAIL reset_drop_pending got=%b exp=0", dp1); end
  endtask

  task automatic test_classify();
    logic [71:0] exp;
    filter = 3'b111; ready = 1'b1; en = 1'b1;
    drive_ev(1, 1, 0, 0, 32'h100, 32'h200, 32'h0, 32'h0, 5'd0);
    tick();
    exp = rec(3'd2, 5'b10000, 32'h100, 32'h200);
    checks++; if (o1.valid !== 1'b1 || o1.data !== exp) begin failures++;
      $display("FAIL branch_latency got=%b/%h exp=1/%h", o1.valid, o1.data, exp); end
    drive_ev(0, 0, 0, 1, 32'h104, 32'h0, 32'h1234, 32'hDEAD, 5'd5);
    tick();
    exp = rec(3'd3, 5'd5, 32'h104, 32'hDEAD);
    checks++; if (o1.data !== exp) begin failures++;
      $display("FAIL regwb_record got=%h exp=%h", o1.data, exp); end
    checks++; if (lvl1 !== 5'd1) begin failures++;
      $display("FAIL push_pop_level got=%0d exp=1", lvl1); end
    drive_ev(1, 0, 1, 1, 32'h108, 32'h300, 32'h77, 32'h1, 5'd7);
    tick();
    exp = rec(3'd2, 5'b01000, 32'h108, 32'h300);
    checks++; if (o1.data !== exp) begin failures++;
      $display("FAIL branch_priority got=%h exp=%h", o1.data, exp); end
    filter = 3'b101;
    drive_ev(1, 0, 0, 1, 32'h10C, 32'h400, 32'h88, 32'h2, 5'd9);
    tick();
    exp = rec(3'd3, 5'd9, 32'h10C, 32'h2);
    checks++; if (o1.data !== exp) begin failures++;
      $display("FAIL regwb_over_exec got=%h exp=%h", o1.data, exp); end
    filter = 3'b001;
    tick();
    exp = rec(3'd1, 5'd0, 32'h10C, 32'h88);
    checks++; if (o1.data !== exp) begin failures++;
      $display("FAIL exec_record got=%h exp=%h", o1.data, exp); end
    filter = 3'b110;
    drive_ev(0, 0, 0, 0, 32'h114, 32'h0, 32'h99, 32'h0, 5'd0);
    tick();
    checks++; if (o1.valid !== 1'b0 || lvl1 !== 5'd0) begin failures++;
      $display("FAIL no_match got=%b/%0d exp=0/0", o1.valid, lvl1); end
    idle();
    tick();
  endtask

  task automatic test_overflow();
    logic [71:0] exp;
    filter = 3'b001; ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_ev(0, 0, 0, 0, 32'h1000 + 32'(i * 4), 32'h0, 32'(i), 32'h0, 5'd0);
      tick();
    end
    idle();
    checks++; if (lvl1 !== 5'd16 || dp1 !== 1'b1) begin failures++;
      $display("FAIL fill_level got=%0d/%b exp=16/1", lvl1, dp1); end
    exp = rec(3'd1, 5'd0, 32'h1000, 32'h0);
    checks++; if (o1.data !== exp) begin failures++;
      $display("FAIL hold_head got=%h exp=%h", o1.data, exp); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++; if (lvl1 !== 5'd15 || dp1 !== 1'b1) begin failures++;
      $display("FAIL after_pop got=%0d/%b exp=15/1", lvl1, dp1); end
    tick();
    checks++; if (lvl1 !== 5'd16 || dp1 !== 1'b0) begin failures++;
      $display("FAIL overflow_written got=%0d/%b exp=16/0", lvl1, dp1); end
    ready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      exp = rec(3'd1, 5'd0, 32'h1000 + 32'(k * 4), 32'(k));
      checks++; if (o1.data !== exp) begin failures++;
        $display("FAIL drain_order_%0d got=%h exp=%h", k, o1.data, exp); end
      tick();
    end
    exp = rec(3'd4, 5'd0, 32'd4, 32'h0);
    checks++; if (o1.valid !== 1'b1 || o1.data !== exp) begin failures++;
      $display("FAIL overflow_record got=%b/%h exp=1/%h", o1.valid, o1.data, exp); end
    drive_ev(0, 0, 0, 0, 32'h5000, 32'h0, 32'h55, 32'h0, 5'd0);
    tick();
    idle();
    exp = rec(3'd1, 5'd0, 32'h5000, 32'h55);
    checks++; if (o1.data !== exp || lvl1 !== 5'd1) begin failures++;
      $display("FAIL stream_continues got=%h/%0d exp=%h/1", o1.data, lvl1, exp); end
    tick();
  endtask

  task automatic test_full_pop_event();
    logic [71:0] exp;
    filter = 3'b001; ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_ev(0, 0, 0, 0, 32'h2000 + 32'(i * 4), 32'h0, 32'(i), 32'h0, 5'd0);
      tick();
    end
    ready = 1'b1;
    drive_ev(0, 0, 0, 0, 32'h2100, 32'h0, 32'hAA, 32'h0, 5'd0);
    tick();
    idle();
    ready = 1'b0;
    checks++; if (lvl1 !== 5'd15 || dp1 !== 1'b1) begin failures++;
      $display("FAIL full_pop_event got=%0d/%b exp=15/1", lvl1, dp1); end
    tick();
    ready = 1'b1;
    repeat (15) tick();
    exp = rec(3'd4, 5'd0, 32'd1, 32'h0);
    checks++; if (o1.data !== exp) begin failures++;
      $display("FAIL overflow_one got=%h exp=%h", o1.data, exp); end
    tick();
    checks++; if (lvl1 !== 5'd0 || o1.valid !== 1'b0) begin failures++;
      $display("FAIL drained got=%0d/%b exp=0/0", lvl1, o1.valid); end
  endtask

  task automatic test_saturation();
    logic [71:0] exp;
    filter = 3'b001; ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 36; i++) begin
      drive_ev(0, 0, 0, 0, 32'h3000 + 32'(i * 4), 32'h0, 32'(i), 32'h0, 5'd0);
      tick();
    end
    idle();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    ready = 1'b1;
    repeat (15) tick();
    exp = rec(3'd4, 5'd0, 32'd15, 32'h0);
    checks++; if (o2.data !== exp) begin failures++;
      $display("FAIL saturated_count got=%h exp=%h", o2.data, exp); end
    exp = rec(3'd4, 5'd0, 32'd20, 32'h0);
    checks++; if (o1.data !== exp) begin failures++;
      $display("FAIL wide_count got=%h exp=%h", o1.data, exp); end
    tick();
    checks++; if (lvl2 !== 5'd0 || dp2 !== 1'b0) begin failures++;
      $display("FAIL sat_drained got=%0d/%b exp=0/0", lvl2, dp2); end
  endtask

  task automatic test_en_off_flush();
    logic [71:0] exp;
    filter = 3'b001; ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive_ev(0, 0, 0, 0, 32'h4000 + 32'(i * 4), 32'h0, 32'(i), 32'h0, 5'd0);
      tick();
    end
    en = 1'b0;
    ready = 1'b1;
    repeat (16) tick();
    exp = rec(3'd4, 5'd0, 32'd3, 32'h0);
    checks++; if (o1.data !== exp || lvl1 !== 5'd1) begin failures++;
      $display("FAIL en_off_flush got=%h/%0d exp=%h/1", o1.data, lvl1, exp); end
    tick();
    checks++; if (lvl1 !== 5'd0 || o1.valid !== 1'b0 || dp1 !== 1'b0) begin failures++;
      $display("FAIL en_off_quiet got=%0d/%b/%b exp=0/0/0", lvl1, o1.valid, dp1); end
    idle();
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [71:0] exp;
    filter = 3'b001; ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_ev(0, 0, 0, 0, 32'h6000 + 32'(i * 4), 32'h0, 32'(i), 32'h0, 5'd0);
      tick();
    end
    idle();
    checks++; if (lvl1 !== 5'd5) begin failures++;
      $display("FAIL pre_reset_level got=%0d exp=5", lvl1); end
    rst_n = 1'b0;
    tick();
    checks++; if (o1.valid !== 1'b0 || o1.data !== 72'h0 || lvl1 !== 5'd0 || dp1 !== 1'b0)
    begin failures++;
      $display("FAIL mid_reset got=%b/%h/%0d/%b exp=0/0/0/0", o1.valid, o1.data, lvl1, dp1);
    end
    rst_n = 1'b1;
    drive_ev(0, 0, 0, 0, 32'h7000, 32'h0, 32'h66, 32'h0, 5'd0);
    tick();
    idle();
    exp = rec(3'd1, 5'd0, 32'h7000, 32'h66);
    checks++; if (lvl1 !== 5'd1 || o1.data !== exp) begin failures++;
      $display("FAIL post_reset got=%0d/%h exp=1/%h", lvl1, o1.data, exp); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; filter = 3'b000; ready = 1'b0;
    idle();
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_classify();
    test_overflow();
    test_full_pop_event();
    test_saturation();
    test_en_off_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
